// File: rtl/acc_executor.sv
// Execute stage of the 8-bit accumulator CPU: register ops, RAM operand reads with
// timeout, RAM writes, jumps and HALT. All outputs are registered.
module acc_executor #(
    parameter logic [7:0] ACC_RESET_VAL  = 8'h00,
    parameter int         TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    output logic [7:0] acc,
    output logic       flag_z,
    output logic       flag_c,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_data,
    input  logic       mem_valid,
    output logic       pc_load,
    output logic [7:0] pc_target,
    output logic       mem_err,
    output logic       halted
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALT} state_t;

    state_t     state_q;
    logic [7:0] acc_q, addr_q, wdata_q, pc_target_q, cnt_q;
    logic [3:0] page_q, rd_op_q;
    logic       z_q, c_q, mem_rd_q, mem_wr_q, pc_load_q, mem_err_q, halted_q;

    logic [3:0] op, arg;
    logic [7:0] b, acc_d;
    logic [8:0] sum9, diff9;
    logic       c_d, z_d;

    assign arg = instr[3:0];

    // One ALU serves both paths: immediates while IDLE, the RAM operand while waiting.
    always_comb begin
        op    = (state_q == S_WAIT) ? rd_op_q : instr[7:4];
        b     = (state_q == S_WAIT) ? mem_data : {4'h0, arg};
        sum9  = {1'b0, acc_q} + {1'b0, b};
        diff9 = {1'b0, acc_q} - {1'b0, b};
        acc_d = acc_q;
        c_d   = c_q;
        case (op)
            4'h1, 4'h5: acc_d = b;
            4'h2:       acc_d = {arg, acc_q[3:0]};
            4'h3, 4'h6: {c_d, acc_d} = sum9;
            4'h4:       {c_d, acc_d} = diff9;
            4'h8:       acc_d = acc_q & b;
            4'h9:       acc_d = acc_q | b;
            4'hA:       acc_d = acc_q ^ b;
            4'hB: begin
                if (arg[3]) {acc_d, c_d} = {1'b0, acc_q};
                else        {c_d, acc_d} = {acc_q, 1'b0};
            end
            default: ;
        endcase
        z_d = (acc_d == 8'h00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= ACC_RESET_VAL;
            page_q      <= 4'h0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            pc_load_q   <= 1'b0;
            pc_target_q <= 8'h00;
            mem_err_q   <= 1'b0;
            halted_q    <= 1'b0;
            rd_op_q     <= 4'h0;
            cnt_q       <= 8'h00;
        end else begin
            mem_wr_q  <= 1'b0;
            pc_load_q <= 1'b0;
            case (state_q)
                S_IDLE: if (instr_valid) begin
                    case (instr[7:4])
                        4'h0: ;
                        4'h5, 4'h6, 4'h8, 4'h9, 4'hA: begin
                            state_q  <= S_WAIT;
                            rd_op_q  <= instr[7:4];
                            mem_rd_q <= 1'b1;
                            addr_q   <= {page_q, arg};
                            cnt_q    <= 8'h00;
                        end
                        4'h7: begin
                            mem_wr_q <= 1'b1;
                            addr_q   <= {page_q, arg};
                            wdata_q  <= acc_q;
                        end
                        4'hC: page_q <= arg;
                        4'hD: begin
                            pc_load_q   <= 1'b1;
                            pc_target_q <= {page_q, arg};
                        end
                        4'hE: if (z_q) begin
                            pc_load_q   <= 1'b1;
                            pc_target_q <= {page_q, arg};
                        end
                        4'hF: begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                        default: begin
                            acc_q <= acc_d;
                            z_q   <= z_d;
                            c_q   <= c_d;
                        end
                    endcase
                end
                S_WAIT: begin
                    if (mem_valid) begin
                        acc_q    <= acc_d;
                        z_q      <= z_d;
                        c_q      <= c_d;
                        mem_rd_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        mem_rd_q  <= 1'b0;
                        mem_err_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'h01;
                    end
                end
                S_HALT: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign acc         = acc_q;
    assign flag_z      = z_q;
    assign flag_c      = c_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign pc_load     = pc_load_q;
    assign pc_target   = pc_target_q;
    assign mem_err     = mem_err_q;
    assign halted      = halted_q;
endmodule

// File: tb/tb_acc_executor.sv
// Directed bench for acc_executor: an instruction-level model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_acc_executor;
    logic       clk = 1'b0, reset = 1'b1;
    logic       instr_valid = 1'b0, mem_valid = 1'b0;
    logic [7:0] instr = 8'h00, mem_data = 8'h00;
    logic       instr_ready, flag_z, flag_c, mem_rd, mem_wr, pc_load, mem_err, halted;
    logic [7:0] acc, mem_addr, mem_wdata, pc_target;

    int n_cmp = 0, n_bad = 0;

    acc_executor dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .acc(acc), .flag_z(flag_z), .flag_c(flag_c),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data(mem_data), .mem_valid(mem_valid), .pc_load(pc_load),
        .pc_target(pc_target), .mem_err(mem_err), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction-level model: plain integer arithmetic, one update per clock edge.
    int  m_acc, m_page, m_z, m_c, m_rd, m_wr, m_addr, m_wdata, m_pcl, m_pct, m_err, m_halt;
    int  m_busy, m_op, m_waited;
    bit  chk_en = 1'b0;

    task automatic set_acc(input int v);
        m_acc = v & 255;
        m_z   = (m_acc == 0);
    endtask

    task automatic jump(input int a);
        m_pcl = 1;
        m_pct = m_page * 16 + a;
    endtask

    task automatic exec(input int op, input int a);
        int t;
        case (op)
            1:  set_acc(a);
            2:  set_acc(a * 16 + m_acc % 16);
            3:  begin t = m_acc + a; m_c = (t > 255); set_acc(t); end
            4:  begin m_c = (m_acc < a); set_acc(m_acc - a + 256); end
            5, 6, 8, 9, 10: begin
                m_busy = 1; m_op = op; m_rd = 1; m_addr = m_page * 16 + a; m_waited = 0;
            end
            7:  begin m_wr = 1; m_addr = m_page * 16 + a; m_wdata = m_acc; end
            11: if (a >= 8) begin m_c = m_acc % 2; set_acc(m_acc / 2); end
                else begin m_c = m_acc / 128; set_acc(m_acc * 2); end
            12: m_page = a;
            13: jump(a);
            14: if (m_z == 1) jump(a);
            15: m_halt = 1;
            default: ;
        endcase
    endtask

    task automatic finish_read(input int d);
        int t;
        case (m_op)
            5:  set_acc(d);
            6:  begin t = m_acc + d; m_c = (t > 255); set_acc(t); end
            8:  set_acc(m_acc & d);
            9:  set_acc(m_acc | d);
            default: set_acc(m_acc ^ d);
        endcase
        m_busy = 0; m_rd = 0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_acc = 0; m_page = 0; m_z = 0; m_c = 0; m_rd = 0; m_wr = 0; m_addr = 0;
            m_wdata = 0; m_pcl = 0; m_pct = 0; m_err = 0; m_halt = 0; m_busy = 0;
            m_op = 0; m_waited = 0;
            chk_en = 1'b1;
        end else begin
            m_wr = 0; m_pcl = 0;
            if (m_busy == 1) begin
                if (mem_valid) finish_read(int'(mem_data));
                else begin
                    m_waited++;
                    if (m_waited == 15) begin m_busy = 0; m_rd = 0; m_err = 1; end
                end
            end else if (m_halt == 0 && instr_valid) begin
                exec(int'(instr[7:4]), int'(instr[3:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m.acc", acc, 8'(m_acc));
            chk("m.z", {7'h0, flag_z}, 8'(m_z));
            chk("m.c", {7'h0, flag_c}, 8'(m_c));
            chk("m.rd", {7'h0, mem_rd}, 8'(m_rd));
            chk("m.wr", {7'h0, mem_wr}, 8'(m_wr));
            chk("m.addr", mem_addr, 8'(m_addr));
            chk("m.wdata", mem_wdata, 8'(m_wdata));
            chk("m.pcl", {7'h0, pc_load}, 8'(m_pcl));
            chk("m.pct", pc_target, 8'(m_pct));
            chk("m.err", {7'h0, mem_err}, 8'(m_err));
            chk("m.halt", {7'h0, halted}, 8'(m_halt));
            chk("m.ready", {7'h0, instr_ready}, 8'(m_busy == 0 && m_halt == 0));
        end
    end

    task automatic cyc(input logic iv, input logic [7:0] ins, input logic mv, input logic [7:0] md);
        instr_valid = iv; instr = ins; mem_valid = mv; mem_data = md;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_acc", acc, 8'h00);
        chk("rst_ready", {7'h0, instr_ready}, 8'h01);
        reset = 1'b0;

        cyc(1, 8'h1F, 0, 0); cyc(1, 8'h31, 0, 0);
        chk("addi_acc", acc, 8'h10); chk("addi_c", {7'h0, flag_c}, 8'h00);
        cyc(1, 8'h1F, 0, 0); cyc(1, 8'h2F, 0, 0); cyc(1, 8'h31, 0, 0);
        chk("wrap_acc", acc, 8'h00); chk("wrap_c", {7'h0, flag_c}, 8'h01);
        chk("wrap_z", {7'h0, flag_z}, 8'h01);
        cyc(1, 8'h13, 0, 0); cyc(1, 8'h45, 0, 0);
        chk("subi_acc", acc, 8'hFE); chk("subi_c", {7'h0, flag_c}, 8'h01);

        cyc(1, 8'hC4, 0, 0); cyc(1, 8'h52, 0, 0);
        chk("ldm_rd", {7'h0, mem_rd}, 8'h01); chk("ldm_addr", mem_addr, 8'h42);
        chk("ldm_ready", {7'h0, instr_ready}, 8'h00);
        cyc(1, 8'h10, 0, 0); cyc(0, 8'h00, 0, 0); cyc(0, 8'h00, 1, 8'hA5);
        chk("ldm_acc", acc, 8'hA5); chk("ldm_rd_drop", {7'h0, mem_rd}, 8'h00);
        cyc(1, 8'h77, 0, 0);
        chk("stm_wr", {7'h0, mem_wr}, 8'h01); chk("stm_addr", mem_addr, 8'h47);
        chk("stm_wdata", mem_wdata, 8'hA5);
        cyc(0, 8'h00, 0, 0);
        chk("stm_pulse", {7'h0, mem_wr}, 8'h00);

        cyc(1, 8'h51, 0, 0);
        repeat (14) cyc(0, 8'h00, 0, 0);
        chk("tmo_still_rd", {7'h0, mem_rd}, 8'h01);
        cyc(0, 8'h00, 0, 0);
        chk("tmo_err", {7'h0, mem_err}, 8'h01); chk("tmo_acc", acc, 8'hA5);
        chk("tmo_ready", {7'h0, instr_ready}, 8'h01);
        cyc(0, 8'h00, 1, 8'h00);
        chk("stray_mv", acc, 8'hA5);

        cyc(1, 8'hC3, 0, 0);
        cyc(1, 8'h6A, 0, 0); cyc(0, 8'h00, 1, 8'h70);
        chk("addm_acc", acc, 8'h15); chk("addm_c", {7'h0, flag_c}, 8'h01);
        cyc(1, 8'h80, 0, 0); cyc(0, 8'h00, 1, 8'h1F);
        cyc(1, 8'h90, 0, 0); cyc(0, 8'h00, 1, 8'hC0);
        chk("orm_acc", acc, 8'hD5);
        cyc(1, 8'hA0, 0, 0); cyc(0, 8'h00, 1, 8'hD5);
        chk("xorm_z", {7'h0, flag_z}, 8'h01);
        cyc(1, 8'h19, 0, 0); cyc(1, 8'h28, 0, 0); cyc(1, 8'hB0, 0, 0);
        chk("shl_acc", acc, 8'h12); chk("shl_c", {7'h0, flag_c}, 8'h01);
        cyc(1, 8'hB8, 0, 0);
        chk("shr_acc", acc, 8'h09);
        cyc(1, 8'hD5, 0, 0);
        chk("jmp_tgt", pc_target, 8'h35);

        cyc(1, 8'hC2, 0, 0); cyc(1, 8'h10, 0, 0); cyc(1, 8'hE9, 0, 0);
        chk("jz_load", {7'h0, pc_load}, 8'h01); chk("jz_tgt", pc_target, 8'h29);
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h11, 0, 0); cyc(1, 8'hE9, 0, 0);
        chk("jz_untaken", {7'h0, pc_load}, 8'h00);

        cyc(1, 8'h53, 0, 0); cyc(0, 8'h00, 0, 0);
        reset = 1'b1;
        cyc(0, 8'h00, 0, 0);
        reset = 1'b0;
        chk("rst_rd", {7'h0, mem_rd}, 8'h00);
        cyc(0, 8'h00, 1, 8'h77);
        chk("late_mv", acc, 8'h00); chk("late_ready", {7'h0, instr_ready}, 8'h01);

        cyc(1, 8'hF0, 0, 0);
        repeat (20) cyc(1, 8'h15, 0, 0);
        chk("halt_flag", {7'h0, halted}, 8'h01);
        chk("halt_ready", {7'h0, instr_ready}, 8'h00);
        chk("halt_acc", acc, 8'h00);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
